// File: rtl/mo_line_buffer.sv
// Double-buffered motion-object scanline buffer: one bank collects the next line's
// object pixels while the other is read out at HCNT; banks swap on LINE.
module mo_line_buffer (
    input  logic       clk,
    input  logic       RESETn,
    input  logic       ce5,
    input  logic       LINE,
    input  logic       LDH,
    input  logic [7:0] HPOS,
    input  logic       WREN,
    input  logic       PLAYER2,
    input  logic [2:0] AR,
    input  logic [7:0] HCNT,
    output logic [2:0] MOPIX,
    output logic       MOACT
);

    logic             bank;
    logic             rd_bank;
    logic [7:0]       wx;
    logic [7:0]       wr_addr;
    logic [7:0]       next_addr;
    logic [1:0][255:0] flags;
    logic [2:0]       ram [2][256];
    logic             wr_pix;
    logic             rd_flag;
    logic [2:0]       rd_pix;

    always_comb begin
        rd_bank   = ~bank;
        wr_addr   = LDH ? HPOS : wx;
        next_addr = PLAYER2 ? wr_addr - 8'd1 : wr_addr + 8'd1;
        // First opaque pixel at a location wins; later objects are masked by its flag.
        wr_pix    = WREN && !LINE && (AR != 3'd0) && !flags[bank][wr_addr];
        rd_flag   = flags[rd_bank][HCNT];
        rd_pix    = ram[rd_bank][HCNT];
    end

    always_ff @(posedge clk or negedge RESETn) begin
        if (!RESETn) begin
            bank  <= 1'b0;
            wx    <= '0;
            flags <= '0;
            MOPIX <= '0;
            MOACT <= 1'b0;
        end else if (ce5) begin
            MOPIX <= rd_flag ? rd_pix : 3'd0;
            MOACT <= rd_flag;
            if (LINE) begin
                // The bank just displayed becomes the write bank and starts empty.
                bank           <= rd_bank;
                flags[rd_bank] <= '0;
                if (LDH)
                    wx <= HPOS;
            end else begin
                if (WREN)
                    wx <= next_addr;
                else if (LDH)
                    wx <= HPOS;
                if (wr_pix)
                    flags[bank][wr_addr] <= 1'b1;
            end
        end
    end

    // Colour storage is never cleared; the occupied flags alone gate visibility.
    always_ff @(posedge clk) begin
        if (ce5 && wr_pix)
            ram[bank][wr_addr] <= AR;
    end

endmodule

// File: tb/tb_mo_line_buffer.sv
// Self-checking bench for mo_line_buffer: directed scenarios plus randomized traffic,
// compared against a line-level model (a line being composed and a line on display).
module tb_mo_line_buffer;

    logic       clk = 1'b0;
    logic       RESETn;
    logic       ce5;
    logic       LINE;
    logic       LDH;
    logic [7:0] HPOS;
    logic       WREN;
    logic       PLAYER2;
    logic [2:0] AR;
    logic [7:0] HCNT;
    logic [2:0] MOPIX;
    logic       MOACT;

    int checks = 0;
    int errors = 0;

    // Model: -1 means nothing drawn at that x.
    int comp [256];
    int disp [256];
    int m_wx;
    int exp_pix;
    int exp_act;

    mo_line_buffer dut (
        .clk    (clk),
        .RESETn (RESETn),
        .ce5    (ce5),
        .LINE   (LINE),
        .LDH    (LDH),
        .HPOS   (HPOS),
        .WREN   (WREN),
        .PLAYER2(PLAYER2),
        .AR     (AR),
        .HCNT   (HCNT),
        .MOPIX  (MOPIX),
        .MOACT  (MOACT)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 256; i++) begin
            comp[i] = -1;
            disp[i] = -1;
        end
        m_wx    = 0;
        exp_pix = 0;
        exp_act = 0;
    endtask

    task automatic model_pixel(input logic line, input logic ldh, input logic [7:0] hpos,
                               input logic wren, input logic p2, input logic [2:0] ar,
                               input logic [7:0] hcnt);
        int addr;
        exp_act = (disp[hcnt] >= 0) ? 1 : 0;
        exp_pix = (disp[hcnt] >= 0) ? disp[hcnt] : 0;
        addr = ldh ? int'(hpos) : m_wx;
        if (line) begin
            disp = comp;
            for (int i = 0; i < 256; i++) comp[i] = -1;
            if (ldh) m_wx = hpos;
        end else begin
            if (ldh) m_wx = hpos;
            if (wren) begin
                if (ar != 0 && comp[addr] < 0) comp[addr] = ar;
                m_wx = (addr + (p2 ? 255 : 1)) % 256;
            end
        end
    endtask

    // One pixel period: ce5 for one clock, checked 1 time unit after the edge,
    // optionally followed by an idle clock where outputs must hold.
    task automatic step(input logic line, input logic ldh, input logic [7:0] hpos,
                        input logic wren, input logic p2, input logic [2:0] ar,
                        input logic [7:0] hcnt);
        LINE = line; LDH = ldh; HPOS = hpos; WREN = wren; PLAYER2 = p2; AR = ar; HCNT = hcnt;
        ce5 = 1'b1;
        @(posedge clk);
        model_pixel(line, ldh, hpos, wren, p2, ar, hcnt);
        #1;
        ce5 = 1'b0;
        LINE = $urandom_range(0, 1); WREN = $urandom_range(0, 1); LDH = $urandom_range(0, 1);
        AR = 3'($urandom); HCNT = 8'($urandom);
        check("mopix", 32'(MOPIX), 32'(exp_pix));
        check("moact", 32'(MOACT), 32'(exp_act));
        if ($urandom_range(0, 1) == 1) begin
            @(posedge clk);
            #1;
            check("mopix_hold", 32'(MOPIX), 32'(exp_pix));
            check("moact_hold", 32'(MOACT), 32'(exp_act));
        end
    endtask

    task automatic wr(input logic ldh, input logic [7:0] hpos, input logic p2, input logic [2:0] ar);
        step(1'b0, ldh, hpos, 1'b1, p2, ar, 8'($urandom));
    endtask

    task automatic new_line();
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 8'($urandom));
    endtask

    task automatic rd_expect(input logic [7:0] hcnt, input logic [2:0] pix, input logic act);
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, hcnt);
        check("plan_pix", 32'(MOPIX), 32'(pix));
        check("plan_act", 32'(MOACT), 32'(act));
    endtask

    initial begin
        logic [2:0] basic [8];
        basic = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd1};
        RESETn = 1'b0; ce5 = 1'b0; LINE = 1'b0; LDH = 1'b0; HPOS = '0;
        WREN = 1'b0; PLAYER2 = 1'b0; AR = '0; HCNT = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_pix", 32'(MOPIX), 32'd0);
        check("reset_act", 32'(MOACT), 32'd0);
        RESETn = 1'b1;

        // Basic write/read
        for (int i = 0; i < 8; i++) wr(i == 0, 8'h40, 1'b0, basic[i]);
        new_line();
        for (int i = 0; i < 8; i++) rd_expect(8'(8'h40 + i), basic[i], 1'b1);
        rd_expect(8'h3F, 3'd0, 1'b0);
        rd_expect(8'h48, 3'd0, 1'b0);

        // Priority and transparency
        for (int i = 0; i < 4; i++) wr(i == 0, 8'h10, 1'b0, 3'd5);
        wr(1'b1, 8'h12, 1'b0, 3'd0);
        for (int i = 0; i < 3; i++) wr(1'b0, 8'h00, 1'b0, 3'd3);
        new_line();
        for (int i = 0; i < 4; i++) rd_expect(8'(8'h10 + i), 3'd5, 1'b1);
        rd_expect(8'h14, 3'd3, 1'b1);
        rd_expect(8'h15, 3'd3, 1'b1);

        // Flip and wrap, both directions
        wr(1'b1, 8'h01, 1'b1, 3'd2);
        wr(1'b0, 8'h00, 1'b1, 3'd4);
        wr(1'b0, 8'h00, 1'b1, 3'd6);
        new_line();
        rd_expect(8'h01, 3'd2, 1'b1);
        rd_expect(8'h00, 3'd4, 1'b1);
        rd_expect(8'hFF, 3'd6, 1'b1);
        wr(1'b1, 8'hFE, 1'b0, 3'd1);
        wr(1'b0, 8'h00, 1'b0, 3'd2);
        wr(1'b0, 8'h00, 1'b0, 3'd3);
        new_line();
        rd_expect(8'hFE, 3'd1, 1'b1);
        rd_expect(8'hFF, 3'd2, 1'b1);
        rd_expect(8'h00, 3'd3, 1'b1);

        // Swap clears and double buffering
        new_line();
        wr(1'b1, 8'h20, 1'b0, 3'd7);
        new_line();
        wr(1'b1, 8'h30, 1'b0, 3'd1);
        rd_expect(8'h20, 3'd7, 1'b1);
        new_line();
        rd_expect(8'h20, 3'd0, 1'b0);
        rd_expect(8'h30, 3'd1, 1'b1);

        // Write on the LINE cycle is dropped and wx holds; LDH+WREN writes at HPOS
        wr(1'b1, 8'h50, 1'b0, 3'd1);
        step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 3'd6, 8'h00);
        wr(1'b0, 8'h00, 1'b0, 3'd2);
        wr(1'b1, 8'h80, 1'b0, 3'd4);
        wr(1'b0, 8'h00, 1'b0, 3'd5);
        new_line();
        rd_expect(8'h51, 3'd2, 1'b1);
        rd_expect(8'h52, 3'd0, 1'b0);
        rd_expect(8'h80, 3'd4, 1'b1);
        rd_expect(8'h81, 3'd5, 1'b1);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            step($urandom_range(0, 63) == 0, $urandom_range(0, 15) == 0, 8'($urandom),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, 3'($urandom), 8'($urandom));
        end

        // Reset mid-write while pixels are visible
        wr(1'b1, 8'h90, 1'b0, 3'd3);
        new_line();
        rd_expect(8'h90, 3'd3, 1'b1);
        LDH = 1'b0; LINE = 1'b0; WREN = 1'b1; AR = 3'd7; ce5 = 1'b1;
        #3;
        RESETn = 1'b0;
        #1;
        model_reset();
        check("async_reset_pix", 32'(MOPIX), 32'd0);
        check("async_reset_act", 32'(MOACT), 32'd0);
        @(posedge clk);
        #1;
        ce5 = 1'b0;
        RESETn = 1'b1;
        new_line();
        for (int h = 0; h < 256; h++) step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 8'(h));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mo_line_buffer.md
# mo_line_buffer

Double-buffered motion-object scanline buffer. It sits directly downstream of the motion-object picture ROM/shifter and consumes its 3-bit serial pixel stream `AR`. While one bank is being written with the objects for the next scanline, the other bank is read out at display position `HCNT`. Banks swap at each line start. The buffer delivers the motion-object pixel (`MOPIX`) and its active flag (`MOACT`) to the video mixer.

## Interface
- No parameters. Buffer depth is fixed at 256 pixels per bank, 2 banks.
- `clk` in 1: system clock.
- `RESETn` in 1: asynchronous, active-low reset.
- `ce5` in 1: pixel-rate clock enable, the same enable that advances the picture shifter. All state changes except reset are qualified by `ce5`.
- `LINE` in 1: start-of-scanline strobe, sampled on `ce5`. Swaps banks.
- `LDH` in 1: load horizontal write position from `HPOS`, sampled on `ce5`.
- `HPOS` in 8: object horizontal start position.
- `WREN` in 1: `AR` carries a valid object pixel this `ce5`.
- `PLAYER2` in 1: cocktail flip. Write position decrements instead of increments.
- `AR` in 3: object pixel colour from the shifter; 0 = transparent.
- `HCNT` in 8: display x position of the read bank.
- `MOPIX` out 3: motion-object pixel colour at `HCNT`, registered.
- `MOACT` out 1: pixel at `HCNT` was written this line, registered.

## Operation
- **Storage**
  - Each bank has a 256×3 colour RAM and 256 occupied flags held in flops.
  - `bank` (1 bit) selects the write bank. The read bank is `~bank`.
- **Write side** (on `ce5`)
  - If `LDH`: `wx <= HPOS`, and the effective address this cycle is `HPOS`.
  - Otherwise the effective address is the current `wx`.
  - If `WREN` and no `LINE`:
    - Address step: effective address ±1 (+1 normally, −1 when `PLAYER2`=1), modulo 256. Wrap 255→0 (or 0→255) is legal and continues writing.
    - If `AR != 0` and the occupied flag at the effective address is 0: write `AR` into colour RAM and set the flag.
    - Otherwise the write is suppressed, but the address still steps.
  - Priority rule: first non-transparent pixel written to a location wins. Later objects never overwrite it.
- **Read side** (on `ce5`)
  - `MOPIX <= flag_rd[HCNT] ? ram_rd[HCNT] : 3'd0`.
  - `MOACT <= flag_rd[HCNT]`.
  - The read bank's colour RAM is never cleared. The flags alone gate the output.
- **Line swap** (on `ce5` with `LINE`)
  - `bank <= ~bank`.
  - All 256 flags of the old read bank, which becomes the new write bank, are cleared in that same cycle.
  - Any `WREN` write on the `LINE` cycle is discarded, and `wx` does not step.
  - `LDH` on the `LINE` cycle still loads `wx`.
  - The read output on the `LINE` cycle uses the pre-swap read bank.
- **Reset** (`RESETn`=0, asynchronous)
  - `bank`=0, `wx`=0, all flags of both banks cleared, `MOPIX`=0, `MOACT`=0.
  - Colour RAM contents are don't-care.
  - Reset mid-line aborts any object being drawn. After release, nothing is visible until data is written and a `LINE` swap occurs.

## Timing
- One pixel per `ce5`. At least one `clk` between `ce5` pulses is required; `ce5` may be tied high.
- Read latency: `MOPIX`/`MOACT` reflect the `HCNT` sampled at the previous `ce5` (1 `ce5` latency).
- Write-to-visible latency: a pixel written on line N appears on `MOPIX` only after the next `LINE`, during line N+1 readout.
- Flag test and set are resolved within a single `ce5` cycle. Two consecutive `ce5` writes to the same address (possible only via `LDH`) see the earlier write's flag.
- Between `ce5` pulses all state holds. Outputs are stable for a full pixel period.

## Test plan
- **Reset:** assert `RESETn`=0 mid-write → `MOPIX`=0, `MOACT`=0 immediately. Release, issue `LINE`, sweep `HCNT` 0..255 → all outputs 0.
- **Basic write/read:** `LDH` with `HPOS`=0x40, then 8 `WREN` pixels `AR`=1..7,1; `LINE`; read `HCNT`=0x40..0x47 → `MOPIX`=1,2,3,4,5,6,7,1, `MOACT`=1. `HCNT`=0x3F and 0x48 → 0.
- **Priority/transparency:**
  - Object A: `HPOS`=0x10, `AR`=5 ×4.
  - Object B: `HPOS`=0x12, `AR`=0,3,3,3.
  - After `LINE`: 0x10..0x13 = 5; 0x14, 0x15 = 3.
- **Flip and wrap:** `PLAYER2`=1, `HPOS`=0x01, `AR`=2,4,6 → after `LINE`: 0x01=2, 0x00=4, 0xFF=6. Repeat with `PLAYER2`=0, `HPOS`=0xFE, `AR`=1,2,3 → 0xFE=1, 0xFF=2, 0x00=3.
- **Swap clears and double buffering:**
  - Line N: write 0x20=7.
  - `LINE`, then line N+1: write 0x30=1 while reading 0x20.
  - Expected: 0x20 reads 7 during line N+1.
  - Next `LINE`: 0x20 reads 0, 0x30 reads 1.
- **Simultaneous events:** `WREN` with `AR`=6 on the same `ce5` as `LINE` → pixel absent after the following swap, and `wx` unchanged. `LDH`+`WREN` same `ce5` with `HPOS`=0x80, `AR`=4 → 0x80=4, next pixel lands at 0x81.
